// File: rtl/seven_seg_pkg.sv
// Shared constants, display-contents struct and hex-to-segment table for the
// seven-segment scan controller (optional dimming is enabled by SEVEN_SEG_DIM_EN).
package seven_seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam int         IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // One complete frame's worth of display contents.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    // Active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit common-anode scan controller with frame-boundary content updates.
// Define SEVEN_SEG_DIM_EN to add the bright[3:0] PWM dimming input.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RST_N,
`ifdef SEVEN_SEG_DIM_EN
    input  logic [3:0]  bright,
`endif
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_value,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_blank,
    output logic        frame_start,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int              CNT_W    = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    disp_t            act_q, act_d;
    disp_t            pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             wr_ready_q, wr_ready_d;
    logic             frame_start_q, frame_start_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             pre_last;
    logic             boundary;
    logic             xfer;
    logic             slot_on;
    logic [3:0]       cur_nibble;
    logic [6:0]       dec_seg;

`ifdef SEVEN_SEG_DIM_EN
    logic [3:0]       pwm_q, pwm_d;
`endif

    assign cur_nibble = act_q.value[{idx_q, 2'b00} +: 4];

    seven_seg_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        pre_last = (pre_q == PRE_LAST);
        boundary = pre_last && (idx_q == IDX_LAST);
        pre_d    = pre_last ? '0 : pre_q + 1'b1;
        idx_d    = pre_last ? idx_q + 1'b1 : idx_q;

        // Pending can only accept while empty, so a transfer and a
        // boundary copy never compete for the same pending entry.
        xfer         = wr_valid && wr_ready_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (boundary && pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
        end
        if (xfer) begin
            pend_d       = '{value: wr_value, dp: wr_dp, blank: wr_blank};
            pend_valid_d = 1'b1;
        end
        wr_ready_d    = !pend_valid_d;
        frame_start_d = boundary;

        slot_on = (pre_q != '0) && !act_q.blank[idx_q];
`ifdef SEVEN_SEG_DIM_EN
        slot_on = slot_on && (pwm_q <= bright);
        pwm_d   = pwm_q + 1'b1;
`endif
        an_d  = slot_on ? ~(4'b0001 << idx_q) : AN_OFF;
        seg_d = slot_on ? dec_seg : SEG_OFF;
        dp_d  = slot_on ? ~act_q.dp[idx_q] : 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pre_q         <= '0;
            idx_q         <= '0;
            act_q         <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            wr_ready_q    <= 1'b1;
            frame_start_q <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            act_q         <= act_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            wr_ready_q    <= wr_ready_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

`ifdef SEVEN_SEG_DIM_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`endif

    assign wr_ready    = wr_ready_q;
    assign frame_start = frame_start_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with DIGIT_CYCLES=4; honours SEVEN_SEG_DIM_EN.
module tb_seven_seg_scan_ctrl;

    localparam int DC    = 4;
    localparam int FRAME = 4 * DC;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_value = '0;
    logic [3:0]  wr_dp = '0;
    logic [3:0]  wr_blank = '0;
    logic        frame_start;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [3:0]  bright = 4'hF;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scan_ctrl #(.DIGIT_CYCLES(DC)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
`ifdef SEVEN_SEG_DIM_EN
        .bright      (bright),
`endif
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_value    (wr_value),
        .wr_dp       (wr_dp),
        .wr_blank    (wr_blank),
        .frame_start (frame_start),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference model: time in the frame comes from a plain cycle count.
    int unsigned n = 0;
    logic        m_pv = 1'b0;
    logic [15:0] act_v = '0, pend_v = '0;
    logic [3:0]  act_dp = '0, pend_dp = '0, act_bl = '0, pend_bl = '0;

    task automatic model_step();
        exp_t e;
        int unsigned p, idx, br;
        bit on, bnd, xf;
        logic [3:0] nib;
        logic [3:0] one;
        one = 4'b0001;
        if (!RST_N) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, rdy: 1'b1, fs: 1'b0};
            n = 0; m_pv = 0;
            act_v = '0; act_dp = '0; act_bl = '0;
        end else begin
`ifdef SEVEN_SEG_DIM_EN
            br = bright;
`else
            br = 15;
`endif
            p   = n % DC;
            idx = (n / DC) % 4;
            on  = (p != 0) && !act_bl[idx] && ((n % 16) <= br);
            nib = act_v[idx*4 +: 4];
            e.an  = on ? ~(one << idx) : 4'hF;
            e.seg = on ? seg_tab[nib] : 7'h7F;
            e.dp  = on ? ~act_dp[idx] : 1'b1;
            bnd = (n % FRAME) == FRAME - 1;
            xf  = wr_valid && !m_pv;
            if (bnd && m_pv) begin
                act_v = pend_v; act_dp = pend_dp; act_bl = pend_bl;
                m_pv = 0;
            end
            if (xf) begin
                pend_v = wr_value; pend_dp = wr_dp; pend_bl = wr_blank;
                m_pv = 1;
            end
            e.rdy = !m_pv;
            e.fs  = bnd;
            n++;
        end
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    task automatic check(input string name, input logic [7:0] a, input logic [7:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h at %0t", name, a, e, $time);
        end
    endtask

    // Monitor: outputs change every cycle, so each cycle is one presented result.
    initial forever begin
        exp_t e;
        @(negedge CLK);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an", {4'h0, an}, {4'h0, e.an});
            check("seg", {1'b0, seg}, {1'b0, e.seg});
            check("dp", {7'h0, dp}, {7'h0, e.dp});
            check("wr_ready", {7'h0, wr_ready}, {7'h0, e.rdy});
            check("frame_start", {7'h0, frame_start}, {7'h0, e.fs});
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        int k;
        wr_value = v; wr_dp = d; wr_blank = b; wr_valid = 1'b1;
        k = 0;
        @(negedge CLK);
        while (!wr_ready && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL handshake: wr_ready stayed 0 for %0d cycles, required 1", k);
        end
        @(posedge CLK);
        #1 wr_valid = 1'b0;
    endtask

    task automatic do_reset(input int k);
        RST_N = 1'b0;
        cycles(k);
        RST_N = 1'b1;
    endtask

    initial begin
        #1;
        cycles(3);
        RST_N = 1'b1;
        bright = 4'hF;

        cycles(5);
        do_write(16'h12AF, 4'b0001, 4'b0000);
        cycles(3 * FRAME);

        do_write(16'h12AF, 4'b0001, 4'b0000);
        do_write(16'h0001, 4'b0000, 4'b0000);
        cycles(3 * FRAME);

        do_write(16'h5678, 4'b1010, 4'b1100);
        cycles(4 * FRAME);

        cycles(6);
        do_write(16'hBEEF, 4'b1111, 4'b0000);
        cycles(1);
        do_reset(3);
        cycles(2 * FRAME);

        bright = 4'd3;
        do_write(16'h9C3D, 4'b0110, 4'b0000);
        cycles(5 * FRAME);

        for (int i = 0; i < 300; i++) begin
            bright = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0: if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 4));
                1, 2: begin
                    wr_value = 16'($urandom); wr_dp = 4'($urandom); wr_blank = 4'($urandom);
                    wr_valid = 1'b1;
                    cycles($urandom_range(1, 3));
                    wr_valid = 1'b0;
                end
                default: do_write(16'($urandom), 4'($urandom),
                                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
            endcase
            cycles($urandom_range(0, 24));
        end

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
